wb_rr_arbiter: RTL and testbench

- Round-robin bus arbiter for the 4-master / 8-slave shared 16-bit Wishbone interconnect.
- Takes one request per master (that master's CYC) and issues a registered one-hot grant. The shared bus uses the grant to steer its master-side mux and its ack/err/rty returns.
- Holds a grant for the full bus cycle and rotates priority fairly between masters.
- Can optionally revoke a stalled grant with a watchdog.

---
 rtl/wb_bus_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 26 ++
 rtl/wb_rr_arbiter.sv | 111 +++++++++++
 tb/tb_wb_rr_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// Shared constants, types and helpers for the 4-master / 8-slave 16-bit Wishbone interconnect.
package wb_bus_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned MID_W       = 2;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1024;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [NUM_MASTERS-1:0] mid_onehot(input logic [MID_W-1:0] id);
    logic [NUM_MASTERS-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first eligible index after last_owner_i (mod NUM_MASTERS).
module rr_priority_pick
  import wb_bus_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] eligible_i,
  input  logic [MID_W-1:0]       last_owner_i,
  output logic [MID_W-1:0]       pick_o,
  output logic                   valid_o
);

  logic [MID_W-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = last_owner_i + MID_W'(k);
      if (!valid_o && eligible_i[idx]) begin
        pick_o  = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone bus arbiter with registered one-hot grant held for the whole bus cycle.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_bus_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic                   ack_i,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MID_W-1:0]       owner_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  arb_state_t             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MID_W-1:0]       owner_q;
  logic [MID_W-1:0]       last_q;
  logic                   busy_q;

  logic [NUM_MASTERS-1:0] block_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic [MID_W-1:0]       pick;
  logic                   pick_valid;
  logic                   wd_expire;

  assign eligible = request & ~block_mask;

  rr_priority_pick u_pick (
    .eligible_i   (eligible),
    .last_owner_i (last_q),
    .pick_o       (pick),
    .valid_o      (pick_valid)
  );

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0]            wd_q;
  logic                   timeout_q;
  logic [NUM_MASTERS-1:0] block_q;

  // Release has priority: expiry only counts while the owner still requests.
  assign wd_expire = (state_q == GRANT) && request[owner_q] && !ack_i &&
                     (wd_q == TIMEOUT - 16'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      block_q   <= '0;
    end else begin
      timeout_q <= wd_expire;
      block_q   <= block_q & request;
      if (wd_expire) block_q[owner_q] <= 1'b1;
      if (state_q == IDLE || ack_i) wd_q <= '0;
      else                          wd_q <= wd_q + 16'd1;
    end
  end

  assign timeout_o  = timeout_q;
  assign block_mask = block_q;
`else
  logic [16:0] unused_cfg;
  assign unused_cfg = {ack_i, TIMEOUT};
  assign wd_expire  = 1'b0;
  assign timeout_o  = 1'b0;
  assign block_mask = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= MID_W'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= mid_onehot(pick);
            owner_q <= pick;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!request[owner_q] || wd_expire) begin
            grant_q <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) assert ($onehot0(grant_q));
  end

  assign grant   = grant_q;
  assign owner_o = owner_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed + randomized bench for wb_rr_arbiter against an integer-level round-robin reference model.
module tb_wb_rr_arbiter;

  localparam logic [15:0] TB_TIMEOUT = 16'd8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk_i;
  logic       rst_i;
  logic [3:0] request;
  logic       ack_i;
  logic [3:0] grant;
  logic [1:0] owner_o;
  logic       busy_o;
  logic       timeout_o;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner -1 means idle.
  int m_owner = -1;
  int m_last  = 3;
  int m_wd    = 0;
  bit m_to    = 1'b0;
  bit m_block [4];

  wb_rr_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .request   (request),
    .ack_i     (ack_i),
    .grant     (grant),
    .owner_o   (owner_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=hang required=finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [3:0] q, input bit a);
    bit nb [4];
    if (r) begin
      m_owner = -1; m_last = 3; m_wd = 0; m_to = 1'b0;
      for (int i = 0; i < 4; i++) m_block[i] = 1'b0;
      return;
    end
    m_to = 1'b0;
    for (int i = 0; i < 4; i++) nb[i] = m_block[i] && q[i];
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && q[c] && !m_block[c]) begin
          m_owner = c;
          m_wd    = 0;
        end
      end
    end else if (!q[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (TO_EN && !a && m_wd == int'(TB_TIMEOUT) - 1) begin
      m_to        = 1'b1;
      nb[m_owner] = 1'b1;
      m_last      = m_owner;
      m_owner     = -1;
    end else begin
      m_wd = a ? 0 : m_wd + 1;
    end
    for (int i = 0; i < 4; i++) m_block[i] = nb[i];
  endtask

  task automatic cyc(input bit r, input logic [3:0] q, input bit a);
    logic [3:0] eg;
    rst_i = r; request = q; ack_i = a;
    @(posedge clk_i);
    model_edge(r, q, a);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check("grant",   16'(grant),     16'(eg));
    check("owner",   16'(owner_o),   16'((m_owner < 0) ? 0 : m_owner));
    check("busy",    16'(busy_o),    16'(m_owner >= 0));
    check("timeout", 16'(timeout_o), 16'(m_to));
    check("onehot0", 16'($onehot0(grant)), 16'd1);
  endtask

  initial begin
    logic [3:0] rq;
    int m;
    rst_i = 1'b1; request = '0; ack_i = 1'b0;

    cyc(1, 4'b0000, 0);
    cyc(1, 4'b0000, 0);
    check("reset_grant", 16'(grant), 16'h0);
    check("reset_timeout", 16'(timeout_o), 16'h0);

    // single master: 1-cycle grant latency, release after drop
    cyc(0, 4'b0001, 0);
    check("single_grant", 16'(grant), 16'h1);
    check("single_owner", 16'(owner_o), 16'h0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0001, 0);
    cyc(0, 4'b0000, 0);
    check("single_release", 16'(grant), 16'h0);

    // rotation with all masters requesting
    for (int s = 1; s <= 4; s++) begin
      m = s % 4;
      cyc(0, 4'b1111, 0);
      check("rot_grant", 16'(grant), 16'(1 << m));
      cyc(0, 4'b1111, 0);
      cyc(0, 4'b1111, 0);
      rq = 4'b1111;
      rq[m] = 1'b0;
      cyc(0, rq, 0);
      check("rot_dead", 16'(grant), 16'h0);
    end
    cyc(0, 4'b0000, 0);

    // no preemption: master 2 held while master 0 waits
    cyc(0, 4'b0100, 0);
    check("nopre_grant2", 16'(grant), 16'h4);
    for (int i = 0; i < 3; i++) cyc(0, 4'b0101, 0);
    check("nopre_held", 16'(grant), 16'h4);
    cyc(0, 4'b0001, 0);
    check("nopre_dead", 16'(grant), 16'h0);
    cyc(0, 4'b0001, 0);
    check("nopre_grant0", 16'(grant), 16'h1);
    cyc(0, 4'b0000, 0);

    // skip idle masters: last_owner=1, master 3 wins over 0
    cyc(0, 4'b0010, 0);
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b1001, 0);
    check("skip_grant3", 16'(grant), 16'h8);
    cyc(0, 4'b0000, 0);

    // mid-transfer reset restarts priority at master 0
    cyc(0, 4'b0100, 0);
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b0010, 0);
    check("mreset_grant1", 16'(grant), 16'h2);
    cyc(1, 4'b0110, 0);
    check("mreset_drop", 16'(grant), 16'h0);
    cyc(0, 4'b0110, 0);
    check("mreset_regrant", 16'(grant), 16'h2);
    cyc(0, 4'b0000, 0);

    // stalled master 0 with ack_i low
    cyc(0, 4'b0001, 0);
    check("to_grant0", 16'(grant), 16'h1);
    for (int i = 0; i < 7; i++) cyc(0, 4'b0011, 0);
    cyc(0, 4'b0011, 0);
    if (TO_EN) begin
      check("to_pulse", 16'(timeout_o), 16'h1);
      check("to_revoke", 16'(grant), 16'h0);
      cyc(0, 4'b0011, 0);
      check("to_next_m1", 16'(grant), 16'h2);
      cyc(0, 4'b0001, 0);
      cyc(0, 4'b0001, 0);
      check("to_blocked", 16'(grant), 16'h0);
      cyc(0, 4'b0000, 0);
      cyc(0, 4'b0001, 0);
      check("to_reraise", 16'(grant), 16'h1);
    end else begin
      for (int i = 0; i < 12; i++) cyc(0, 4'b0011, 0);
      check("noto_held", 16'(grant), 16'h1);
      check("noto_pulse", 16'(timeout_o), 16'h0);
    end
    cyc(0, 4'b0000, 0);
    cyc(0, 4'b0000, 0);

    // randomized traffic against the model
    rq = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      cyc(($urandom_range(0, 149) == 0), rq, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
